// File: rtl/core_dbg_apb_bridge.sv
// APB slave bridging debug-master transfers onto the core debug register req/ack port.
// Optional ack timeout enabled by defining CORE_DBG_APB_TIMEOUT_EN.
module core_dbg_apb_bridge #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      sel,
    input  logic                      enable,
    input  logic                      wr_rd,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrobe,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      slverr,
    output logic                      core_dbg_req,
    output logic                      core_dbg_wr_rd,
    output logic [ADDR_WIDTH-1:0]     core_dbg_addr,
    output logic [DATA_WIDTH-1:0]     core_dbg_wdata,
    output logic [DATA_WIDTH/8-1:0]   core_dbg_wstrobe,
    input  logic                      core_dbg_ack,
    input  logic [DATA_WIDTH-1:0]     core_dbg_rdata,
    input  logic                      core_dbg_err
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Elaboration-time parameter sanity checks
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
        $error("core_dbg_apb_bridge: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (NUM_REGS > (64'd1 << ADDR_WIDTH)) begin : g_bad_nr
        $error("core_dbg_apb_bridge: NUM_REGS exceeds address space");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("core_dbg_apb_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  req_q, req_d;
    logic                  dwr_q, dwr_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
    logic [STRB_W-1:0]     dstrb_q, dstrb_d;
    logic                  in_range_c;

    assign in_range_c = 32'(addr) < NUM_REGS;

`ifdef CORE_DBG_APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_c;

    // True in the REQ cycle that would bring the wait count up to the limit
    assign timeout_c = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        slverr_d = slverr_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        dwr_d    = dwr_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dstrb_d  = dstrb_q;
`ifdef CORE_DBG_APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel && !enable) begin
                    dwr_d    = wr_rd;
                    daddr_d  = addr;
                    dwdata_d = wdata;
                    dstrb_d  = wr_rd ? wstrobe : '0;
                    if (in_range_c) begin
                        req_d   = 1'b1;
                        state_d = S_REQ;
`ifdef CORE_DBG_APB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        slverr_d = 1'b1;
                        rdata_d  = '0;
                        ready_d  = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (core_dbg_ack) begin
                    req_d    = 1'b0;
                    rdata_d  = dwr_q ? '0 : core_dbg_rdata;
                    slverr_d = core_dbg_err;
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end
`ifdef CORE_DBG_APB_TIMEOUT_EN
                else if (timeout_c) begin
                    req_d    = 1'b0;
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                slverr_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            dwr_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            dwr_q    <= dwr_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dstrb_q  <= dstrb_d;
        end
    end

`ifdef CORE_DBG_APB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ready            = ready_q;
    assign rdata            = rdata_q;
    assign slverr           = slverr_q;
    assign core_dbg_req     = req_q;
    assign core_dbg_wr_rd   = dwr_q;
    assign core_dbg_addr    = daddr_q;
    assign core_dbg_wdata   = dwdata_q;
    assign core_dbg_wstrobe = dstrb_q;

endmodule

// File: tb/tb_core_dbg_apb_bridge.sv
// Testbench for core_dbg_apb_bridge: directed vector table, hand sequences for
// reset/protocol corners, and randomized transfers against a transaction model.
module tb_core_dbg_apb_bridge;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned TO = 8;
`ifdef CORE_DBG_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic          sel;
    logic          enable;
    logic          wr_rd;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrobe;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          core_dbg_req;
    logic          core_dbg_wr_rd;
    logic [AW-1:0] core_dbg_addr;
    logic [DW-1:0] core_dbg_wdata;
    logic [3:0]    core_dbg_wstrobe;
    logic          core_dbg_ack;
    logic [DW-1:0] core_dbg_rdata;
    logic          core_dbg_err;

    int n_tests = 0;
    int n_fail  = 0;

    core_dbg_apb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .sel(sel), .enable(enable),
        .wr_rd(wr_rd), .wdata(wdata), .wstrobe(wstrobe), .ready(ready),
        .rdata(rdata), .slverr(slverr), .core_dbg_req(core_dbg_req),
        .core_dbg_wr_rd(core_dbg_wr_rd), .core_dbg_addr(core_dbg_addr),
        .core_dbg_wdata(core_dbg_wdata), .core_dbg_wstrobe(core_dbg_wstrobe),
        .core_dbg_ack(core_dbg_ack), .core_dbg_rdata(core_dbg_rdata),
        .core_dbg_err(core_dbg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            d;        // req cycles before the ack cycle
        logic [DW-1:0] rd;
        logic          err;
        logic          drop;     // deassert sel once req is seen
        int            exp_lat;  // setup-to-ready cycles
        logic          exp_slverr;
        logic [DW-1:0] exp_rdata;
        int            exp_reqs;
    } vec_t;

    function automatic vec_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                                input logic [3:0] st, input int d, input logic [DW-1:0] rd,
                                input logic e, input logic dr, input int lat, input logic se,
                                input logic [DW-1:0] erd, input int reqs);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = wd; v.strb = st; v.d = d; v.rd = rd;
        v.err = e; v.drop = dr; v.exp_lat = lat; v.exp_slverr = se;
        v.exp_rdata = erd; v.exp_reqs = reqs;
        return v;
    endfunction

    // Transaction-level expectation from the bridge's response rules
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (32'(v.addr) >= NR) begin
            r.exp_lat = 1; r.exp_slverr = 1'b1; r.exp_rdata = '0; r.exp_reqs = 0;
        end else if (TO_EN && v.d >= int'(TO)) begin
            r.exp_lat = int'(TO) + 1; r.exp_slverr = 1'b1; r.exp_rdata = '0; r.exp_reqs = int'(TO);
        end else begin
            r.exp_lat = v.d + 2; r.exp_slverr = v.err;
            r.exp_rdata = v.wr ? '0 : v.rd; r.exp_reqs = v.d + 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  cyc;
        int  reqs;
        int  bad;
        bit  got;
        addr = v.addr; wr_rd = v.wr; wdata = v.wdata; wstrobe = v.strb;
        sel = 1'b1; enable = 1'b0; core_dbg_ack = 1'b0;
        step();
        enable = 1'b1;
        cyc = 1; reqs = 0; bad = 0; got = 1'b0;
        while (!got && cyc <= 300) begin
            if (ready) begin
                got = 1'b1;
            end else begin
                core_dbg_ack   = 1'b0;
                core_dbg_rdata = $urandom;
                core_dbg_err   = 1'($urandom);
                if (core_dbg_req) begin
                    reqs++;
                    if (core_dbg_addr !== v.addr || core_dbg_wr_rd !== v.wr ||
                        core_dbg_wdata !== v.wdata ||
                        core_dbg_wstrobe !== (v.wr ? v.strb : 4'b0000)) bad++;
                    if (reqs - 1 == v.d) begin
                        core_dbg_ack = 1'b1; core_dbg_rdata = v.rd; core_dbg_err = v.err;
                    end
                    if (v.drop) begin
                        sel = 1'b0; enable = 1'b0;
                    end
                end
                step();
                cyc++;
            end
        end
        chk({tag, "_latency"}, DW'(cyc), DW'(v.exp_lat));
        chk({tag, "_slverr"}, DW'(slverr), DW'(v.exp_slverr));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_req_cycles"}, DW'(reqs), DW'(v.exp_reqs));
        chk({tag, "_dbg_fields_bad"}, DW'(bad), '0);
        sel = 1'b0; enable = 1'b0; core_dbg_ack = 1'b0;
        step();
        chk({tag, "_ready_one_cycle"}, DW'(ready), '0);
        chk({tag, "_slverr_cleared"}, DW'(slverr), '0);
        chk({tag, "_rdata_hold"}, rdata, v.exp_rdata);
    endtask

    vec_t tbl[9];

    initial begin
        int bad;
        vec_t v;
        tbl[0] = mk(5'd3,  1'b1, 32'hDEADBEEF, 4'b0101, 0, 32'h0,        1'b0, 1'b0, 2, 1'b0, 32'h0,        1);
        tbl[1] = mk(5'd7,  1'b0, 32'h0,        4'b1111, 5, 32'h12345678, 1'b0, 1'b0, 7, 1'b0, 32'h12345678, 6);
        tbl[2] = mk(5'd31, 1'b0, 32'h0,        4'b0000, 0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h0,        0);
        tbl[3] = mk(5'd5,  1'b0, 32'h0,        4'b1010, 1, 32'hAAAA5555, 1'b1, 1'b0, 3, 1'b1, 32'hAAAA5555, 2);
        tbl[4] = mk(5'd0,  1'b1, 32'h01020304, 4'b1111, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1'b0, 32'h0,        1);
        tbl[5] = mk(5'd15, 1'b0, 32'h0,        4'b0000, 2, 32'h0F0F0F0F, 1'b0, 1'b0, 4, 1'b0, 32'h0F0F0F0F, 3);
        tbl[6] = mk(5'd16, 1'b1, 32'hCAFEF00D, 4'b0011, 0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h0,        0);
        tbl[7] = mk(5'd9,  1'b0, 32'h0,        4'b0000, 0, 32'h13572468, 1'b0, 1'b1, 2, 1'b0, 32'h13572468, 1);
        tbl[8] = mk(5'd1,  1'b0, 32'h0,        4'b0000, 7, 32'h55AA55AA, 1'b0, 1'b0, 9, 1'b0, 32'h55AA55AA, 8);

        sel = 1'b0; enable = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0; wstrobe = '0;
        core_dbg_ack = 1'b0; core_dbg_rdata = '0; core_dbg_err = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        step(); step();
        chk("rst_ready", DW'(ready), '0);
        chk("rst_slverr", DW'(slverr), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_req", DW'(core_dbg_req), '0);
        chk("rst_dbg_outs", {core_dbg_wdata[31:10], core_dbg_wr_rd, core_dbg_addr, core_dbg_wstrobe},
            '0);
        chk("rst_dbg_wdata", core_dbg_wdata, '0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Access phase without a setup phase, and stray acks, must not start anything
        bad = 0;
        sel = 1'b1; enable = 1'b1; addr = 5'd3; wr_rd = 1'b1; core_dbg_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (core_dbg_req !== 1'b0 || ready !== 1'b0) bad++;
        end
        chk("idle_access_ignored", DW'(bad), '0);
        sel = 1'b0; enable = 1'b0; core_dbg_ack = 1'b0;
        step();

        // Reset pulsed while waiting for ack
        addr = 5'd2; wr_rd = 1'b1; wdata = 32'h11112222; wstrobe = 4'b1111;
        sel = 1'b1; enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        chk("rst_mid_req_before", DW'(core_dbg_req), DW'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req_async_req", DW'(core_dbg_req), '0);
        chk("rst_mid_req_async_ready", DW'({ready, slverr}), '0);
        chk("rst_mid_req_async_addr", DW'(core_dbg_addr), '0);
        sel = 1'b0; enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_vec(mk(5'd2, 1'b1, 32'h33334444, 4'b1001, 1, 32'h0, 1'b0, 1'b0, 3, 1'b0, 32'h0, 2),
                "post_rst_write");

`ifdef CORE_DBG_APB_TIMEOUT_EN
        run_vec(mk(5'd4, 1'b0, 32'h0, 4'b0000, 1000, 32'hBADBAD00, 1'b0, 1'b0,
                   int'(TO) + 1, 1'b1, 32'h0, int'(TO)), "timeout");
        step();
        core_dbg_ack = 1'b1; core_dbg_rdata = 32'hFFFFFFFF; core_dbg_err = 1'b1;
        step();
        core_dbg_ack = 1'b0;
        chk("late_ack_req", DW'(core_dbg_req), '0);
        chk("late_ack_ready_slverr", DW'({ready, slverr}), '0);
        chk("late_ack_rdata", rdata, '0);
        step();
`endif

        for (int i = 0; i < 40; i++) begin
            v.addr  = AW'($urandom_range(0, 31));
            v.wr    = 1'($urandom);
            v.wdata = $urandom;
            v.strb  = 4'($urandom);
            v.d     = int'($urandom_range(0, 10));
            v.rd    = $urandom;
            v.err   = ($urandom_range(0, 3) == 0);
            v.drop  = ($urandom_range(0, 7) == 0);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
